// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction-fetch front end.
package fetch_pkg;

    typedef enum logic [2:0] {
        S_HALT  = 3'd0,
        S_RUN   = 3'd1,
        S_STEP  = 3'd2,
        S_BRK   = 3'd3,
        S_FAULT = 3'd4
    } state_e;

    localparam logic [1:0]  MODE_HALT = 2'b00;
    localparam logic [1:0]  MODE_RUN  = 2'b01;
    localparam logic [1:0]  MODE_STEP = 2'b10;
    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    // Requested operating state for a mode_i encoding; the reserved 11 behaves as HALT.
    function automatic state_e mode_to_state(input logic [1:0] mode);
        case (mode)
            MODE_RUN:  return S_RUN;
            MODE_STEP: return S_STEP;
            default:   return S_HALT;
        endcase
    endfunction

endpackage

// File: rtl/fetch_unit_tick_gen.sv
// Clock-enable generator: tick is high on every TICK_DIV-th enabled, non-held cycle.
module tick_gen #(
    parameter int unsigned TICK_DIV = 50_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic enable,
    input  logic hold,
    input  logic clear,
    output logic tick
);

    localparam int unsigned     CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

    logic [CNT_W-1:0] cnt_q;

    // Holding at CNT_LAST keeps tick asserted until the stall releases.
    always_ff @(posedge clk) begin
        if (rst || clear) begin
            cnt_q <= '0;
        end else if (enable && !hold) begin
            cnt_q <= (cnt_q == CNT_LAST) ? '0 : cnt_q + CNT_W'(1);
        end
    end

    assign tick = enable && (cnt_q == CNT_LAST);

endmodule

// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC, run/halt/step control, redirect and fault handling.
// Optional breakpoint halt is built when FETCH_BREAKPOINT_EN is defined.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int unsigned    XLEN         = 32,
    parameter logic [XLEN-1:0] RESET_VECTOR = '0,
    parameter int unsigned    IMEM_DEPTH   = 64,
    parameter int unsigned    TICK_DIV     = 50_000_000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [1:0]      mode_i,
    input  logic            step_i,
    input  logic            stall_i,
    input  logic            redirect_valid_i,
    input  logic [XLEN-1:0] redirect_pc_i,
    output logic [XLEN-1:0] imem_addr_o,
    input  logic [31:0]     imem_rdata_i,
    output logic [31:0]     instr_o,
    output logic [XLEN-1:0] pc_o,
    output logic            instr_valid_o,
    output logic [2:0]      state_o,
    output logic            fault_o,
    input  logic [XLEN-1:0] bp_addr_i,
    output logic            bp_hit_o
);

    localparam logic [XLEN-1:0] IMEM_BYTES = XLEN'(IMEM_DEPTH * 4);
    localparam logic [XLEN-1:0] LAST_PC    = XLEN'(IMEM_DEPTH * 4 - 4);

    state_e          state_q, state_n;
    logic [XLEN-1:0] pc_q, pc_n;
    logic [31:0]     instr_q, instr_n;
    logic [XLEN-1:0] pc_out_q, pc_out_n;
    logic            valid_q, valid_n;
    logic            fault_q, fault_n;
    logic            bp_hit_q, bp_hit_n;
    logic            step_q;
    logic            step_pend_q, step_pend_n;
    logic            step_rise;
    logic            redirect_bad;
    logic            tick;

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick_gen (
        .clk    (clk),
        .rst    (rst),
        .enable (state_q == S_RUN),
        .hold   (stall_i),
        .clear  (redirect_valid_i || (state_q != S_RUN)),
        .tick   (tick)
    );

    assign step_rise    = step_i && !step_q;
    assign redirect_bad = (redirect_pc_i[1:0] != 2'b00) || (redirect_pc_i >= IMEM_BYTES);

    // Next-state and datapath update; FAULT freezes everything until reset.
    always_comb begin
        state_n     = state_q;
        pc_n        = pc_q;
        instr_n     = instr_q;
        pc_out_n    = pc_out_q;
        valid_n     = 1'b0;
        fault_n     = fault_q;
        step_pend_n = 1'b0;
        bp_hit_n    = 1'b0;

        if (state_q != S_FAULT) begin
            if (state_q == S_BRK) begin
                state_n = (mode_i == MODE_RUN) ? S_BRK : S_HALT;
            end else begin
                state_n = mode_to_state(mode_i);
            end

            if (state_q == S_STEP) begin
                step_pend_n = step_pend_q || step_rise;
            end

            if (redirect_valid_i) begin
                if (redirect_bad) begin
                    state_n = S_FAULT;
                    fault_n = 1'b1;
                end else begin
                    pc_n = redirect_pc_i;
                end
            end else if (!stall_i && (((state_q == S_RUN) && tick) ||
                                      ((state_q == S_STEP) && step_pend_q))) begin
                instr_n     = imem_rdata_i;
                pc_out_n    = pc_q;
                valid_n     = 1'b1;
                pc_n        = (pc_q == LAST_PC) ? '0 : pc_q + XLEN'(4);
                step_pend_n = 1'b0;
`ifdef FETCH_BREAKPOINT_EN
                if ((state_q == S_RUN) && (pc_q == bp_addr_i)) begin
                    state_n = S_BRK;
                end
`endif
            end
        end

`ifdef FETCH_BREAKPOINT_EN
        bp_hit_n = (state_n == S_BRK);
`endif
    end

`ifndef FETCH_BREAKPOINT_EN
    logic unused_bp_addr;
    assign unused_bp_addr = ^bp_addr_i;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= S_HALT;
            pc_q        <= RESET_VECTOR;
            instr_q     <= NOP_INSTR;
            pc_out_q    <= RESET_VECTOR;
            valid_q     <= 1'b0;
            fault_q     <= 1'b0;
            bp_hit_q    <= 1'b0;
            step_q      <= 1'b0;
            step_pend_q <= 1'b0;
        end else begin
            state_q     <= state_n;
            pc_q        <= pc_n;
            instr_q     <= instr_n;
            pc_out_q    <= pc_out_n;
            valid_q     <= valid_n;
            fault_q     <= fault_n;
            bp_hit_q    <= bp_hit_n;
            step_q      <= step_i;
            step_pend_q <= step_pend_n;
        end
    end

    assign imem_addr_o   = pc_q;
    assign instr_o       = instr_q;
    assign pc_o          = pc_out_q;
    assign instr_valid_o = valid_q;
    assign state_o       = state_q;
    assign fault_o       = fault_q;
    assign bp_hit_o      = bp_hit_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: dut_a (TICK_DIV=4, 64 words), dut_b (TICK_DIV=1, 4 words).
module tb_fetch_unit;

    logic        clk;
    logic        rst;
    logic [1:0]  mode;
    logic        step;
    logic        stall;
    logic        redir_v;
    logic [31:0] redir_pc;
    logic [31:0] bp_addr;

    logic [31:0] addr_a, rdata_a, instr_a, pc_a;
    logic        valid_a, fault_a, bp_a;
    logic [2:0]  state_a;
    logic [31:0] addr_b, rdata_b, instr_b, pc_b;
    logic        valid_b, fault_b, bp_b;
    logic [2:0]  state_b;

    int n_checks = 0;
    int n_fail   = 0;

    // Memory models: each word encodes its own byte address.
    assign rdata_a = {16'hC0DE, addr_a[15:0]};
    assign rdata_b = {16'hBEEF, addr_b[15:0]};

    fetch_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .IMEM_DEPTH(64), .TICK_DIV(4)) dut_a (
        .clk(clk), .rst(rst), .mode_i(mode), .step_i(step), .stall_i(stall),
        .redirect_valid_i(redir_v), .redirect_pc_i(redir_pc),
        .imem_addr_o(addr_a), .imem_rdata_i(rdata_a), .instr_o(instr_a), .pc_o(pc_a),
        .instr_valid_o(valid_a), .state_o(state_a), .fault_o(fault_a),
        .bp_addr_i(bp_addr), .bp_hit_o(bp_a)
    );

    fetch_unit #(.XLEN(32), .RESET_VECTOR(32'h0), .IMEM_DEPTH(4), .TICK_DIV(1)) dut_b (
        .clk(clk), .rst(rst), .mode_i(mode), .step_i(step), .stall_i(stall),
        .redirect_valid_i(redir_v), .redirect_pc_i(redir_pc),
        .imem_addr_o(addr_b), .imem_rdata_i(rdata_b), .instr_o(instr_b), .pc_o(pc_b),
        .instr_valid_o(valid_b), .state_o(state_b), .fault_o(fault_b),
        .bp_addr_i(bp_addr), .bp_hit_o(bp_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst      = 1'b1;
        mode     = 2'b00;
        step     = 1'b0;
        stall    = 1'b0;
        redir_v  = 1'b0;
        redir_pc = 32'h0;
        bp_addr  = 32'hFFFF_FFFC;
        next_cycle();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (state_a !== 3'd0) begin n_fail++; $display("FAIL reset_state got %0d want 0", state_a); end
        n_checks++; if (addr_a !== 32'h0) begin n_fail++; $display("FAIL reset_pc got %h want 0", addr_a); end
        n_checks++; if (pc_a !== 32'h0) begin n_fail++; $display("FAIL reset_pc_o got %h want 0", pc_a); end
        n_checks++; if (instr_a !== 32'h0000_0013) begin n_fail++; $display("FAIL reset_instr got %h want 00000013", instr_a); end
        n_checks++; if (valid_a !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", valid_a); end
        n_checks++; if (fault_a !== 1'b0) begin n_fail++; $display("FAIL reset_fault got %b want 0", fault_a); end
        n_checks++; if (bp_a !== 1'b0) begin n_fail++; $display("FAIL reset_bp got %b want 0", bp_a); end
    endtask

    task automatic test_run();
        logic [31:0] exp_pc;
        logic        exp_v;
        do_reset();
        mode = 2'b01;
        next_cycle();
        n_checks++; if (state_a !== 3'd1) begin n_fail++; $display("FAIL run_state got %0d want 1", state_a); end
        exp_pc = 32'h0;
        for (int i = 1; i <= 16; i++) begin
            next_cycle();
            exp_v = (i % 4 == 0);
            n_checks++; if (valid_a !== exp_v) begin n_fail++; $display("FAIL run_valid cyc %0d got %b want %b", i, valid_a, exp_v); end
            if (exp_v) begin
                n_checks++; if (pc_a !== exp_pc) begin n_fail++; $display("FAIL run_pc cyc %0d got %h want %h", i, pc_a, exp_pc); end
                n_checks++; if (instr_a !== {16'hC0DE, exp_pc[15:0]}) begin n_fail++; $display("FAIL run_instr cyc %0d got %h", i, instr_a); end
                exp_pc = exp_pc + 32'd4;
            end
        end
        n_checks++; if (addr_a !== 32'h10) begin n_fail++; $display("FAIL run_next_pc got %h want 10", addr_a); end
    endtask

    task automatic test_step();
        logic [15:0] pat;
        int          n_adv;
        do_reset();
        pat   = 16'b1111_1111_1000_1100;   // bit i drives step_i in cycle i
        n_adv = 0;
        mode  = 2'b10;
        for (int i = 0; i < 16; i++) begin
            step = pat[i];
            next_cycle();
            if (valid_a) begin
                n_checks++;
                if (n_adv >= 2) begin n_fail++; $display("FAIL step_extra cyc %0d pc %h", i, pc_a); end
                else if (pc_a !== 32'(n_adv * 4)) begin n_fail++; $display("FAIL step_pc got %h want %h", pc_a, 32'(n_adv * 4)); end
                n_adv++;
            end
        end
        n_checks++; if (n_adv != 2) begin n_fail++; $display("FAIL step_count got %0d want 2", n_adv); end
        n_checks++; if (state_a !== 3'd2) begin n_fail++; $display("FAIL step_state got %0d want 2", state_a); end
        step = 1'b0;
    endtask

    task automatic test_redirect();
        do_reset();
        mode = 2'b01;
        repeat (4) next_cycle();
        redir_v  = 1'b1;
        redir_pc = 32'h20;
        next_cycle();
        redir_v = 1'b0;
        n_checks++; if (valid_a !== 1'b0) begin n_fail++; $display("FAIL redir_no_valid got %b want 0", valid_a); end
        n_checks++; if (addr_a !== 32'h20) begin n_fail++; $display("FAIL redir_pc got %h want 20", addr_a); end
        for (int i = 1; i <= 4; i++) begin
            next_cycle();
            n_checks++; if (valid_a !== (i == 4)) begin n_fail++; $display("FAIL redir_valid cyc %0d got %b want %b", i, valid_a, (i == 4)); end
        end
        n_checks++; if (pc_a !== 32'h20) begin n_fail++; $display("FAIL redir_pc_o got %h want 20", pc_a); end
        n_checks++; if (instr_a !== 32'hC0DE_0020) begin n_fail++; $display("FAIL redir_instr got %h want c0de0020", instr_a); end
    endtask

    task automatic test_fault();
        logic [31:0] bad [2];
        bad[0] = 32'h22;
        bad[1] = 32'h100;
        for (int k = 0; k < 2; k++) begin
            do_reset();
            redir_v  = 1'b1;
            redir_pc = bad[k];
            next_cycle();
            redir_v = 1'b0;
            n_checks++; if (state_a !== 3'd4) begin n_fail++; $display("FAIL fault_state %h got %0d want 4", bad[k], state_a); end
            n_checks++; if (fault_a !== 1'b1) begin n_fail++; $display("FAIL fault_flag %h got %b want 1", bad[k], fault_a); end
            n_checks++; if (addr_a !== 32'h0) begin n_fail++; $display("FAIL fault_pc %h got %h want 0", bad[k], addr_a); end
            mode = 2'b01;
            for (int i = 0; i < 10; i++) begin
                redir_v  = (i == 5);
                redir_pc = 32'h10;
                next_cycle();
                n_checks++; if (valid_a !== 1'b0) begin n_fail++; $display("FAIL fault_advance cyc %0d got %b want 0", i, valid_a); end
            end
            redir_v = 1'b0;
            n_checks++; if (state_a !== 3'd4) begin n_fail++; $display("FAIL fault_sticky got %0d want 4", state_a); end
            n_checks++; if (addr_a !== 32'h0) begin n_fail++; $display("FAIL fault_pc_hold got %h want 0", addr_a); end
            do_reset();
            n_checks++; if (state_a !== 3'd0) begin n_fail++; $display("FAIL fault_rst_state got %0d want 0", state_a); end
            n_checks++; if (fault_a !== 1'b0) begin n_fail++; $display("FAIL fault_rst_flag got %b want 0", fault_a); end
        end
    endtask

    task automatic test_wrap_stall();
        logic [8:0]  pat;
        logic [31:0] exp_seq [6];
        int          n_adv;
        exp_seq[0] = 32'h0; exp_seq[1] = 32'h4; exp_seq[2] = 32'h8;
        exp_seq[3] = 32'hC; exp_seq[4] = 32'h0; exp_seq[5] = 32'h4;
        pat   = 9'b000_111_000;   // bit i drives stall_i in cycle i
        n_adv = 0;
        do_reset();
        mode = 2'b01;
        next_cycle();
        for (int i = 0; i < 9; i++) begin
            stall = pat[i];
            next_cycle();
            n_checks++; if (valid_b !== !pat[i]) begin n_fail++; $display("FAIL wrap_valid cyc %0d got %b want %b", i, valid_b, !pat[i]); end
            if (valid_b && n_adv < 6) begin
                n_checks++; if (pc_b !== exp_seq[n_adv]) begin n_fail++; $display("FAIL wrap_pc adv %0d got %h want %h", n_adv, pc_b, exp_seq[n_adv]); end
                n_adv++;
            end
        end
        stall = 1'b0;
        n_checks++; if (n_adv != 6) begin n_fail++; $display("FAIL wrap_count got %0d want 6", n_adv); end
        n_checks++; if (instr_b !== 32'hBEEF_0004) begin n_fail++; $display("FAIL wrap_instr got %h want beef0004", instr_b); end
    endtask

    task automatic test_breakpoint();
        logic        exp_v;
        logic        bp_en;
        int          n_adv;
`ifdef FETCH_BREAKPOINT_EN
        bp_en = 1'b1;
`else
        bp_en = 1'b0;
`endif
        n_adv = 0;
        do_reset();
        bp_addr = 32'h8;
        mode    = 2'b01;
        next_cycle();
        for (int i = 1; i <= 20; i++) begin
            next_cycle();
            exp_v = (i % 4 == 0) && (!bp_en || i <= 12);
            n_checks++; if (valid_a !== exp_v) begin n_fail++; $display("FAIL bp_valid cyc %0d got %b want %b", i, valid_a, exp_v); end
            if (i == 12) begin
                n_checks++; if (pc_a !== 32'h8) begin n_fail++; $display("FAIL bp_pc got %h want 8", pc_a); end
                n_checks++; if (bp_a !== bp_en) begin n_fail++; $display("FAIL bp_hit_at got %b want %b", bp_a, bp_en); end
            end
        end
        n_checks++; if (state_a !== (bp_en ? 3'd3 : 3'd1)) begin n_fail++; $display("FAIL bp_state got %0d want %0d", state_a, bp_en ? 3 : 1); end
        n_checks++; if (bp_a !== bp_en) begin n_fail++; $display("FAIL bp_hit got %b want %b", bp_a, bp_en); end
        mode = 2'b00;
        next_cycle();
        n_checks++; if (state_a !== 3'd0) begin n_fail++; $display("FAIL bp_exit_state got %0d want 0", state_a); end
        n_checks++; if (bp_a !== 1'b0) begin n_fail++; $display("FAIL bp_exit_hit got %b want 0", bp_a); end
    endtask

    initial begin
        test_reset();
        test_run();
        test_step();
        test_redirect();
        test_fault();
        test_wrap_stall();
        test_breakpoint();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Parametrised instruction-fetch front end: PC register, tick-enable generator, run/halt/single-step control and branch redirect, driving a combinational instruction memory. Sits between the board top level and the future decode stage. It replaces the free-running PC+4 loop clocked by a divided clock with a single-clock design that advances on a clock enable. Exposes state and fault for LEDs and the 7-segment display.

## Interface
- XLEN, 32, PC and address width
- RESET_VECTOR, 0, PC value after reset; must be word aligned
- IMEM_DEPTH, 64, instruction memory size in 32-bit words; valid byte range is 0 to IMEM_DEPTH*4-1
- TICK_DIV, 50_000_000, clk cycles per RUN-mode advance; 1 means advance every cycle

Ports:
- clk  in  1  single clock
- rst  in  1  synchronous, active-high reset
- mode_i  in  2  00 HALT, 01 RUN, 10 STEP, 11 treated as HALT
- step_i  in  1  level input; rising edge requests one advance in STEP
- stall_i  in  1  blocks any advance while high
- redirect_valid_i  in  1  load redirect_pc_i into PC
- redirect_pc_i  in  XLEN  redirect target
- imem_addr_o  out  XLEN  current PC, driven combinationally from the PC register
- imem_rdata_i  in  32  word at imem_addr_o, same cycle
- instr_o  out  32  last fetched instruction
- pc_o  out  XLEN  address of instr_o
- instr_valid_o  out  1  one-cycle pulse per advance
- state_o  out  3  current FSM state
- fault_o  out  1  sticky fault flag
- bp_addr_i  in  XLEN  breakpoint address
- bp_hit_o  out  1  high while in BRK

## Operation
- Reset values:
  - PC = RESET_VECTOR
  - pc_o = RESET_VECTOR
  - instr_o = 32'h0000_0013 (NOP)
  - instr_valid_o = 0, fault_o = 0, bp_hit_o = 0
  - state = HALT; tick counter = 0; step edge register = 0
- States:
  - HALT: entered when mode_i is 00 or 11.
  - RUN: entered when mode_i is 01.
  - STEP: entered when mode_i is 10.
  - BRK: breakpoint halt, only with the macro.
  - FAULT: terminal; left only by rst.
- Transitions among HALT, RUN and STEP follow mode_i, sampled every cycle.
- BRK exits only to HALT, when mode_i is not 01.
- Advance:
  - Captures instr_o <= imem_rdata_i and pc_o <= PC.
  - Pulses instr_valid_o.
  - Sets PC <= PC+4. At PC = IMEM_DEPTH*4-4 the next PC wraps to 0.
- RUN: advance when tick is high and stall_i is low.
- STEP: a rising edge of step_i sets step_pending.
  - Advance when step_pending is set and stall_i is low; the advance clears step_pending.
  - Further edges while step_pending is set are ignored.
- Tick counter:
  - Counts only in RUN; holds while stall_i is high.
  - Clears on leaving RUN and on a redirect.
  - tick is high when the counter equals TICK_DIV-1; the counter then wraps to 0.
- Redirect (all states except FAULT):
  - Priority over stall and advance; no instr_valid_o that cycle.
  - If redirect_pc_i[1:0] is not 0, or redirect_pc_i >= IMEM_DEPTH*4: go to FAULT, set fault_o, leave PC unchanged.
  - Otherwise PC <= redirect_pc_i.
- FAULT: no advances; all outputs hold.

## Timing
- Fetch latency: advance decided in cycle N; instr_o, pc_o and instr_valid_o are updated after edge N; PC is updated at the same edge.
- RUN with TICK_DIV = D and no stall: one advance every D cycles. The first advance occurs D cycles after entering RUN.
- step_i edge detect adds one cycle: step_i rises in cycle N, advance at edge N+1 at the earliest.
- Simultaneous events:
  - Redirect plus tick: redirect wins; the tick is lost.
  - Stall plus tick: advance deferred; the counter holds at TICK_DIV-1 until stall_i drops.
- rst mid-operation clears everything at the next edge, including FAULT and step_pending.

## Configuration
- FETCH_BREAKPOINT_EN defined:
  - In RUN, an advance whose PC equals bp_addr_i completes normally.
  - Same edge: state moves to BRK and bp_hit_o = 1.
  - STEP advances ignore the breakpoint.
- FETCH_BREAKPOINT_EN undefined:
  - No BRK state; bp_hit_o tied 0; bp_addr_i unused.
  - Port list unchanged.

## Structure
- fetch_pkg holds:
  - state enum (HALT=0, RUN=1, STEP=2, BRK=3, FAULT=4)
  - mode encodings
  - NOP constant 32'h0000_0013
- Sub-module tick_gen (parameter TICK_DIV) with inputs enable, hold and clear, and output tick.

## Test plan
- TICK_DIV=4, RESET_VECTOR=0, RUN for 16 cycles, no stall -> instr_valid_o at cycles 4, 8, 12, 16; pc_o = 0, 4, 8, 12.
- STEP mode with two step_i pulses, then step_i held high -> exactly two advances; pc_o = 0 then 4; no third advance while step_i stays high.
- RUN, redirect_pc_i = 0x20 on a tick cycle -> no instr_valid_o that cycle; next pc_o = 0x20 after a full TICK_DIV period.
- redirect_pc_i = 0x22, then separately 0x100 with IMEM_DEPTH=64 -> state FAULT, fault_o = 1, no further advances; rst returns PC to RESET_VECTOR and state to HALT.
- IMEM_DEPTH=4, TICK_DIV=1, RUN with stall_i high for 3 cycles mid-run -> pc_o sequence 0, 4, 8, 0xC, 0 (wrap); no advance during the stall.
- FETCH_BREAKPOINT_EN, bp_addr_i = 8, RUN -> instr fetched at pc_o = 8, state BRK, bp_hit_o = 1; mode_i = 00 -> HALT, bp_hit_o = 0.
